// File: rtl/triangle_sweep_ctrl_if.sv
// Bundle between the sweep sequencer, its configuration/control source and the
// triangle-wave generator it steers.
interface triangle_sweep_ctrl_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
);
    localparam int AW = $clog2(DEPTH);

    logic             cfg_we;
    logic [AW-1:0]    cfg_addr;
    logic [WIDTH-1:0] cfg_low;
    logic [WIDTH-1:0] cfg_high;
    logic [CNT_W-1:0] cfg_periods;
    logic             start;
    logic             stop;
    logic             loop;
    logic [WIDTH-1:0] wave_in;
    logic             wave_enable;
    logic [WIDTH-1:0] wave_low;
    logic [WIDTH-1:0] wave_high;
    logic [AW-1:0]    seg_idx;
    logic             busy;
    logic             done;

    // Configuration/control side plus the generator feedback path.
    modport master (
        output cfg_we, cfg_addr, cfg_low, cfg_high, cfg_periods,
        output start, stop, loop, wave_in,
        input  wave_enable, wave_low, wave_high, seg_idx, busy, done
    );

    // The sequencer itself.
    modport slave (
        input  cfg_we, cfg_addr, cfg_low, cfg_high, cfg_periods,
        input  start, stop, loop, wave_in,
        output wave_enable, wave_low, wave_high, seg_idx, busy, done
    );
endinterface

// File: rtl/triangle_sweep_ctrl.sv
// Plays a table of {low, high, periods} segments through a triangle-wave
// generator, counting completed periods from the fed-back wave.
module triangle_sweep_ctrl #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    triangle_sweep_ctrl_if.slave bus
);
    localparam int            AW   = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_GAP
    } state_t;

    // Segment table: no reset, contents valid once written.
    logic [WIDTH-1:0] r_tab_low     [DEPTH];
    logic [WIDTH-1:0] r_tab_high    [DEPTH];
    logic [CNT_W-1:0] r_tab_periods [DEPTH];

    state_t           r_state;
    state_t           w_state_next;

    logic             r_en;
    logic [WIDTH-1:0] r_low;
    logic [WIDTH-1:0] r_high;
    logic [AW-1:0]    r_seg;
    logic             r_busy;
    logic             r_done;
    logic             r_seen;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_target;

    logic             w_en_next;
    logic [WIDTH-1:0] w_low_next;
    logic [WIDTH-1:0] w_high_next;
    logic [AW-1:0]    w_seg_next;
    logic             w_done_next;
    logic             w_seen_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic [CNT_W-1:0] w_target_next;

    logic [DEPTH-1:0] w_slot_valid;
    logic             w_ld_valid;
    logic [WIDTH-1:0] w_ld_low;
    logic [WIDTH-1:0] w_ld_high;
    logic [CNT_W-1:0] w_ld_periods;
    logic             w_hit_high;
    logic             w_count;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_period_done;
    logic             w_advance;
    logic             w_wrap;

    always_ff @(posedge clk) begin
        if (bus.cfg_we) begin
            r_tab_low[bus.cfg_addr]     <= bus.cfg_low;
            r_tab_high[bus.cfg_addr]    <= bus.cfg_high;
            r_tab_periods[bus.cfg_addr] <= bus.cfg_periods;
        end
    end

    // A slot with zero periods or an empty/inverted range is skipped.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
            assign w_slot_valid[gi] = (r_tab_periods[gi] != '0) &&
                                      (r_tab_low[gi] < r_tab_high[gi]);
        end
    endgenerate

    assign w_ld_valid    = w_slot_valid[r_seg];
    assign w_ld_low      = r_tab_low[r_seg];
    assign w_ld_high     = r_tab_high[r_seg];
    assign w_ld_periods  = r_tab_periods[r_seg];

    // A period ends on the first return to low after high has been seen.
    assign w_hit_high    = (bus.wave_in == r_high);
    assign w_count       = r_seen && (bus.wave_in == r_low);
    assign w_cnt_inc     = r_cnt + CNT_W'(1);
    assign w_period_done = w_count && (w_cnt_inc == r_target);

    assign w_advance     = ((r_state == S_LOAD) && !w_ld_valid) || (r_state == S_GAP);
    assign w_wrap        = (r_seg != LAST) || bus.loop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE: if (bus.start) w_state_next = S_LOAD;
            S_LOAD: begin
                if (w_ld_valid)  w_state_next = S_RUN;
                else if (w_wrap) w_state_next = S_LOAD;
                else             w_state_next = S_IDLE;
            end
            S_RUN:  if (w_period_done) w_state_next = S_GAP;
            S_GAP:  w_state_next = w_wrap ? S_LOAD : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
        if (bus.stop) w_state_next = S_IDLE;
    end

    always_comb begin
        w_en_next     = r_en;
        w_low_next    = r_low;
        w_high_next   = r_high;
        w_seg_next    = r_seg;
        w_done_next   = 1'b0;
        w_seen_next   = r_seen;
        w_cnt_next    = r_cnt;
        w_target_next = r_target;
        unique case (r_state)
            S_IDLE: begin
                w_en_next = 1'b0;
                if (bus.start) w_seg_next = '0;
            end
            S_LOAD: begin
                if (w_ld_valid) begin
                    w_low_next    = w_ld_low;
                    w_high_next   = w_ld_high;
                    w_target_next = w_ld_periods;
                    w_cnt_next    = '0;
                    w_seen_next   = 1'b0;
                    w_en_next     = 1'b1;
                end
            end
            S_RUN: begin
                if (w_count) begin
                    w_cnt_next  = w_cnt_inc;
                    w_seen_next = 1'b0;
                end else if (w_hit_high) begin
                    w_seen_next = 1'b1;
                end
                if (w_period_done) w_en_next = 1'b0;
            end
            S_GAP: w_en_next = 1'b0;
            default: w_en_next = 1'b0;
        endcase
        if (w_advance) begin
            if (r_seg != LAST) w_seg_next = r_seg + AW'(1);
            else if (bus.loop) w_seg_next = '0;
            else               w_done_next = 1'b1;
        end
        // Abort freezes the slot index and bounds, drops enable, no done.
        if (bus.stop) begin
            w_en_next     = 1'b0;
            w_done_next   = 1'b0;
            w_seg_next    = r_seg;
            w_low_next    = r_low;
            w_high_next   = r_high;
            w_target_next = r_target;
            w_cnt_next    = r_cnt;
            w_seen_next   = r_seen;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_en     <= 1'b0;
            r_low    <= '0;
            r_high   <= '0;
            r_seg    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_seen   <= 1'b0;
            r_cnt    <= '0;
            r_target <= '0;
        end else begin
            r_en     <= w_en_next;
            r_low    <= w_low_next;
            r_high   <= w_high_next;
            r_seg    <= w_seg_next;
            r_busy   <= (w_state_next != S_IDLE);
            r_done   <= w_done_next;
            r_seen   <= w_seen_next;
            r_cnt    <= w_cnt_next;
            r_target <= w_target_next;
        end
    end

    assign bus.wave_enable = r_en;
    assign bus.wave_low    = r_low;
    assign bus.wave_high   = r_high;
    assign bus.seg_idx     = r_seg;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
endmodule

// File: tb/tb_triangle_sweep_ctrl.sv
// Bench for triangle_sweep_ctrl: a stepping triangle generator closes the loop,
// and a segment-timeline model predicts every output cycle by cycle.
module tb_triangle_sweep_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    triangle_sweep_ctrl_if #(.WIDTH(8), .DEPTH(4), .CNT_W(8)) ifc ();

    triangle_sweep_ctrl #(.WIDTH(8), .DEPTH(4), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    // Generator: shows low on the first enabled cycle, then steps by one
    // up to high and back down, repeating while enabled.
    logic       g_run = 1'b0;
    logic       g_up  = 1'b1;
    logic [7:0] g_val = 8'd0;
    assign ifc.wave_in = g_run ? g_val : ifc.wave_low;

    always @(posedge clk) begin
        if (!ifc.wave_enable) begin
            g_run <= 1'b0;
        end else if (!g_run) begin
            g_run <= 1'b1;
            g_val <= 8'(ifc.wave_low + 8'd1);
            g_up  <= (8'(ifc.wave_low + 8'd1) != ifc.wave_high);
        end else if (g_up) begin
            g_val <= 8'(g_val + 8'd1);
            if (8'(g_val + 8'd1) == ifc.wave_high) g_up <= 1'b0;
        end else begin
            g_val <= 8'(g_val - 8'd1);
            if (8'(g_val - 8'd1) == ifc.wave_low) g_up <= 1'b1;
        end
    end

    typedef struct packed {
        logic       en;
        logic [7:0] lo;
        logic [7:0] hi;
        logic [1:0] seg;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    logic [7:0] m_lo [4];
    logic [7:0] m_hi [4];
    logic [7:0] m_p  [4];
    logic [7:0] m_low  = 8'd0;
    logic [7:0] m_high = 8'd0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic push(input logic en, input logic [1:0] seg, input logic busy, input logic done);
        exp_t e;
        e.en = en; e.lo = m_low; e.hi = m_high; e.seg = seg; e.busy = busy; e.done = done;
        q.push_back(e);
    endtask

    // One pass over the table: a LOAD cycle per slot; valid slots then hold
    // enable for 1 + 2*(high-low)*periods cycles followed by one GAP cycle.
    task automatic build_pass(input bit with_done);
        for (int s = 0; s < 4; s++) begin
            push(1'b0, 2'(s), 1'b1, 1'b0);
            if (m_p[s] != 0 && m_lo[s] < m_hi[s]) begin
                m_low  = m_lo[s];
                m_high = m_hi[s];
                for (int n = 0; n < 1 + 2 * (m_hi[s] - m_lo[s]) * m_p[s]; n++)
                    push(1'b1, 2'(s), 1'b1, 1'b0);
                push(1'b0, 2'(s), 1'b1, 1'b0);
            end
        end
        if (with_done) begin
            push(1'b0, 2'd3, 1'b0, 1'b1);
            push(1'b0, 2'd3, 1'b0, 1'b0);
            push(1'b0, 2'd3, 1'b0, 1'b0);
        end
    endtask

    // Activity monitor used by the literal expectations.
    int   mon_cyc, rises, en_cycles, done_cnt, done_at, first_rise, gap, gmin, gmax;
    logic prev_en;

    task automatic mon_clear();
        mon_cyc = 0; rises = 0; en_cycles = 0; done_cnt = 0; done_at = 0;
        first_rise = 0; gap = 0; gmin = 999; gmax = 0; prev_en = 1'b0;
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        mon_cyc++;
        if (ifc.wave_enable) en_cycles++;
        if (ifc.done) begin
            done_cnt++;
            done_at = mon_cyc;
        end
        if (ifc.wave_enable && !prev_en) begin
            if (rises == 0) first_rise = mon_cyc;
            else begin
                if (gap < gmin) gmin = gap;
                if (gap > gmax) gmax = gap;
            end
            rises++;
            gap = 0;
        end else if (!ifc.wave_enable) begin
            gap++;
        end
        prev_en = ifc.wave_enable;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("wave_enable", int'(ifc.wave_enable), int'(e.en));
            chk("wave_low", int'(ifc.wave_low), int'(e.lo));
            chk("wave_high", int'(ifc.wave_high), int'(e.hi));
            chk("seg_idx", int'(ifc.seg_idx), int'(e.seg));
            chk("busy", int'(ifc.busy), int'(e.busy));
            chk("done", int'(ifc.done), int'(e.done));
        end
    end

    task automatic wr(input int a, input int l, input int h, input int p);
        @(negedge clk);
        ifc.cfg_we = 1'b1; ifc.cfg_addr = 2'(a);
        ifc.cfg_low = 8'(l); ifc.cfg_high = 8'(h); ifc.cfg_periods = 8'(p);
        m_lo[a] = 8'(l); m_hi[a] = 8'(h); m_p[a] = 8'(p);
        @(negedge clk);
        ifc.cfg_we = 1'b0;
    endtask

    // Returns one negedge after start was raised; timeline entry i is checked
    // just after the i-th rising edge following the one that samples start.
    task automatic kick(input bit with_done, input int keep);
        @(negedge clk);
        mon_clear();
        build_pass(with_done);
        if (keep >= 0) q = q[0:keep-1];
        ifc.start = 1'b1;
        @(negedge clk);
        ifc.start = 1'b0;
    endtask

    task automatic drain(input string nm);
        for (int i = 0; i < 3000 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL %s: timeline not consumed, %0d entries left, required 0", nm, q.size());
            q.delete();
        end
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, " wave_enable"}, int'(ifc.wave_enable), 0);
        chk({nm, " wave_low"}, int'(ifc.wave_low), 0);
        chk({nm, " wave_high"}, int'(ifc.wave_high), 0);
        chk({nm, " seg_idx"}, int'(ifc.seg_idx), 0);
        chk({nm, " busy"}, int'(ifc.busy), 0);
        chk({nm, " done"}, int'(ifc.done), 0);
    endtask

    initial begin
        ifc.cfg_we = 1'b0; ifc.cfg_addr = '0; ifc.cfg_low = '0; ifc.cfg_high = '0;
        ifc.cfg_periods = '0; ifc.start = 1'b0; ifc.stop = 1'b0; ifc.loop = 1'b0;
        mon_clear();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;

        // Single segment, two periods of 10..13.
        wr(0, 10, 13, 2); wr(1, 0, 0, 0); wr(2, 0, 0, 0); wr(3, 0, 0, 0);
        kick(1'b1, -1);
        drain("single");
        chk("single first_rise", first_rise, 2);
        chk("single en_cycles", en_cycles, 13);
        chk("single done_at", done_at, 19);
        chk("single done_cnt", done_cnt, 1);

        // Every slot invalid: done after four LOAD cycles.
        wr(0, 10, 13, 0);
        kick(1'b1, -1);
        drain("allskip");
        chk("allskip done_at", done_at, 5);
        chk("allskip rises", rises, 0);

        // Four valid slots in order.
        wr(0, 0, 3, 1); wr(1, 5, 6, 3); wr(2, 2, 4, 1); wr(3, 7, 9, 1);
        kick(1'b1, -1);
        drain("four");
        chk("four rises", rises, 4);
        chk("four en_cycles", en_cycles, 24);
        chk("four gap_min", gmin, 2);
        chk("four gap_max", gmax, 2);
        chk("four done_at", done_at, 33);

        // Slots 1 and 2 invalid: skipped back to back.
        wr(1, 1, 9, 0); wr(2, 5, 5, 1);
        kick(1'b1, -1);
        drain("skip");
        chk("skip rises", rises, 2);
        chk("skip en_cycles", en_cycles, 12);
        chk("skip gap", gmin, 4);
        chk("skip done_at", done_at, 19);

        // Looping playback aborted during slot 2 (LOAD of slot 2 is entry 18).
        wr(1, 5, 6, 3); wr(2, 2, 4, 1);
        ifc.loop = 1'b1;
        kick(1'b0, 22);
        repeat (21) @(negedge clk);
        ifc.stop = 1'b1;
        m_low = 8'd2; m_high = 8'd4;
        push(1'b0, 2'd2, 1'b0, 1'b0);
        push(1'b0, 2'd2, 1'b0, 1'b0);
        push(1'b0, 2'd2, 1'b0, 1'b0);
        @(negedge clk);
        ifc.stop = 1'b0;
        drain("stop");
        ifc.loop = 1'b0;
        chk("stop done_cnt", done_cnt, 0);
        chk("stop seg_idx", int'(ifc.seg_idx), 2);

        // Slot 3 rewritten while slot 1 is playing.
        m_lo[3] = 8'd20; m_hi[3] = 8'd22; m_p[3] = 8'd1;
        kick(1'b1, -1);
        repeat (11) @(negedge clk);
        ifc.cfg_we = 1'b1; ifc.cfg_addr = 2'd3;
        ifc.cfg_low = 8'd20; ifc.cfg_high = 8'd22; ifc.cfg_periods = 8'd1;
        @(negedge clk);
        ifc.cfg_we = 1'b0;
        drain("rewrite");
        chk("rewrite wave_low", int'(ifc.wave_low), 20);
        chk("rewrite wave_high", int'(ifc.wave_high), 22);

        // Asynchronous reset in the middle of slot 1, then a full replay.
        kick(1'b1, -1);
        repeat (11) @(negedge clk);
        #2;
        q.delete();
        chk("prerst wave_enable", int'(ifc.wave_enable), 1);
        rst = 1'b1;
        #1;
        chk_reset_outputs("async_rst");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_low = 8'd0; m_high = 8'd0;
        kick(1'b1, -1);
        drain("replay");
        chk("replay done_at", done_at, 33);
        chk("replay wave_low", int'(ifc.wave_low), 20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/triangle_sweep_ctrl.md
# triangle_sweep_ctrl

Sequencer that drives one triangle-wave generator through a programmable table of sweep segments. Each segment supplies a low bound, a high bound and a number of full triangle periods. The block drives the generator's enable, low and high inputs, and watches the generator's output to count completed periods. It sits between a register/config interface and the triangle-wave generator, and supports single-shot or looping playback.

## Interface
- WIDTH, 8: wave amplitude width; matches the generator's WIDTH.
- DEPTH, 4: number of segment slots; power of two, at least 2.
- CNT_W, 8: width of the per-segment period count.
- clk  in  1  rising-edge clock shared with the generator.
- rst  in  1  asynchronous, active-high reset.
- cfg_we  in  1  writes slot cfg_addr on this edge.
- cfg_addr  in  $clog2(DEPTH)  slot index.
- cfg_low  in  WIDTH  segment low bound.
- cfg_high  in  WIDTH  segment high bound.
- cfg_periods  in  CNT_W  full periods to play; 0 means skip the slot.
- start  in  1  level, sampled in IDLE only.
- stop  in  1  level, abort; highest priority.
- loop  in  1  sampled at the end of the last slot; 1 restarts at slot 0.
- wave_in  in  WIDTH  generator output, fed back.
- wave_enable  out  WIDTH=1  generator enable.
- wave_low  out  WIDTH  generator low bound, registered.
- wave_high  out  WIDTH  generator high bound, registered.
- seg_idx  out  $clog2(DEPTH)  current slot.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on normal completion.

## Operation
- Table: DEPTH entries of {low, high, periods}, written synchronously. rst does not clear the table; contents are undefined until written. Writes while busy are allowed. A slot is read only in LOAD, so a write takes effect the next time that slot is loaded.
- States: IDLE, LOAD, RUN, GAP. All outputs are registered.
- IDLE: wave_enable=0. If start=1 and stop=0, set seg_idx to 0 and go to LOAD.
- LOAD (1 cycle), reading slot seg_idx:
  - If periods==0 or low>=high, the slot is invalid. Do not update wave_low/wave_high and go directly to advance.
  - Otherwise latch wave_low, wave_high and the target count, clear the period counter and seen_high, set wave_enable=1, and go to RUN.
- RUN:
  - If wave_in==wave_high, set seen_high.
  - If seen_high and wave_in==wave_low, count one period and clear seen_high. Both tests are evaluated on the same cycle.
  - When the count reaches the target, set wave_enable=0 and go to GAP.
- GAP (1 cycle, enable low so the generator reloads low on the next enable rise): advance.
- Advance:
  - If seg_idx<DEPTH-1: increment seg_idx and go to LOAD.
  - Else if loop=1: set seg_idx to 0 and go to LOAD.
  - Else: pulse done and go to IDLE.
- stop=1 in any state: next edge goes to IDLE with wave_enable=0 and no done pulse. seg_idx and wave_low/wave_high hold their values.
- Invalid-slot skips chain back-to-back through LOAD, one cycle per slot.
  - All slots invalid with loop=0: done pulses after DEPTH LOAD cycles.
  - All slots invalid with loop=1: the block cycles through LOAD indefinitely with busy=1 until stop.
- Reset values: wave_enable=0, wave_low=0, wave_high=0, seg_idx=0, busy=0, done=0, state=IDLE, counters=0. rst mid-segment drops wave_enable asynchronously.

## Timing
- start sampled high at edge k: LOAD after edge k; wave_enable=1 and busy=1 after edge k+1.
- Target period completed when wave_in==wave_low is seen before edge m: wave_enable=0 after edge m; GAP occupies m..m+1; LOAD m+1..m+2; the next valid segment's wave_enable=1 after edge m+2. This gives exactly 2 low cycles between segments.
- done is high for exactly the cycle following the final GAP; busy=0 in that same cycle.
- wave_low and wave_high change only in LOAD, i.e. only while wave_enable=0.
- The period counter is CNT_W bits and never wraps; the target is at most 2^CNT_W-1.

## Test plan
- Slot0={10,13,2}, loop=0, start pulse -> wave_enable rises 2 cycles after start; wave_in follows 10..13..10 twice; wave_enable falls the edge after the second return to 10; done pulses; busy=0.
- Slots {0,3,1},{5,6,3},{2,4,1},{7,9,1}, loop=0 -> seg_idx 0,1,2,3 in order; wave_enable low for exactly 2 cycles between segments; per-segment period counts match.
- Slot1 periods=0, slot2 low=high=5 -> both skipped in consecutive LOAD cycles; wave_low/wave_high unchanged across the skip; no enable pulse for either slot.
- loop=1 with 4 valid slots; assert stop mid-RUN of slot 2 -> wave_enable=0 next edge, IDLE, no done pulse, seg_idx stays 2.
- Rewrite slot 3 to {20,22,1} while slot 1 is running -> slot 3 plays the new values.
- Assert rst mid-RUN -> all outputs return to reset values without waiting for a clock edge; a start after rst release replays from slot 0 with the table contents intact.
